bit_serial_adder: RTL
=====================

// Module: bit_serial_adder
// PURPOSE
//  Multi-bit adder built around one FA_X1 full-adder cell and a carry flop.
//  Adds two WIDTH-bit operands and a carry-in LSB-first, one bit per clock.
//  Sits directly upstream of FA_X1: it sequences the cell's A/B/CI inputs and
//  collects its S/CO outputs, trading latency for a single adder cell.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//  CK     in   1      clock, rising-edge active
//  RN     in   1      asynchronous active-low reset
//  START  in   1      request; sampled only when not BUSY
//  A      in   WIDTH  operand A, captured on accepted START
//  B      in   WIDTH  operand B, captured on accepted START
//  CI     in   1      carry-in, captured on accepted START
//  BUSY   out  1      high while a serial add is in progress
//  DONE   out  1      one-cycle pulse: S/CO valid
//  S      out  WIDTH  sum result, held until next accepted START completes
//  CO     out  1      final carry-out, held like S
// BEHAVIOUR
//  - One clock CK; reset is asynchronous and active-low on RN.
//  - Reset (RN=0): state IDLE; BUSY=0, DONE=0, S=0, CO=0. Shift regs, carry and
//    counter clear. Takes effect immediately, independent of CK.
//  - States: IDLE, RUN, FIN.
//    IDLE: START=1 -> capture A,B into shift regs, carry<=CI, cnt<=0 -> RUN.
//    RUN:  each edge, the FA cell sees a_sr[0], b_sr[0], carry.
//          sum bit shifts into the MSB of the sum shift reg; carry<=FA.CO;
//          a_sr, b_sr shift right; cnt++.
//          When cnt==WIDTH-1 on that edge -> FIN. S<=final sum reg. CO<=FA.CO.
//    FIN:  DONE=1 for exactly this cycle; START=1 -> capture as in IDLE -> RUN
//          (back-to-back accepted), else -> IDLE.
//  - BUSY=1 exactly in RUN. START while BUSY is ignored and operands not resampled.
//  - Latency: START sampled at edge 0 -> bits 0..WIDTH-1 processed at edges
//    1..WIDTH -> DONE high from edge WIDTH to edge WIDTH+1.
//    Throughput: one add per WIDTH+1 cycles.
//  - Result: {CO,S} == A + B + CI, computed modulo 2^(WIDTH+1); no overflow flag.
//  - S/CO change only at the completing edge. They are stable during RUN, still
//    showing the previous result.
//  - Counter width $clog2(WIDTH+1); no wrap possible. WIDTH=1 completes in one RUN
//    cycle.
//  - RN low mid-RUN aborts; the partial result is discarded; outputs read zero.
//  - Simultaneous RN deassert and START: START ignored on that first edge only
//    if recovery is violated; the bench drives START >=1 cycle after RN rises.
// STRUCTURE
//  - Shared package bit_serial_pkg: state_t enum (IDLE/RUN/FIN) and the default
//    WIDTH constant.
//  - One sub-module instance: FA_X1 (A,B,CI,CO,S) as the bit cell. Everything
//    else in this module: FSM, counter, three shift regs, carry flop.
// TESTING (WIDTH=8)
//  1. RN=0 for 3 cycles with START toggling -> BUSY=0, DONE=0, S=8'h00, CO=0.
//  2. A=8'h35,B=8'h4A,CI=0,START 1 cycle -> BUSY 8 cycles, DONE at edge 8,
//     S=8'h7F, CO=0.
//  3. A=8'hFF,B=8'h01,CI=0 -> full ripple: S=8'h00, CO=1. Then A=8'hFF,B=8'hFF,
//     CI=1 -> S=8'hFF, CO=1.
//  4. START held high during RUN with A=8'h11,B=8'h22 changing every cycle ->
//     only the first capture is used; A=8'h0F,B=8'h01 -> S=8'h10, CO=0.
//     Next add starts in FIN cycle: A=8'h80,B=8'h80,CI=0 -> S=8'h00, CO=1,
//     DONE 9 cycles later.
//  5. RN pulsed low at RUN cycle 4 -> all outputs 0, IDLE. A new START with
//     A=8'h01,B=8'h01,CI=1 -> S=8'h03, CO=0.
//  6. 1000 random {A,B,CI} with random START gaps -> every DONE matches
//     {CO,S} == A+B+CI. Check DONE is a one-cycle pulse and BUSY==1 for 8 cycles.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/FA_X1.sv
// Single-bit full-adder cell: S = A ^ B ^ CI, CO = majority(A, B, CI).
module FA_X1 (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic CO,
  output logic S
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one FA_X1 cell plus a carry flop, one bit per clock.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s_c;
  logic               fa_co_c;
  logic [WIDTH-1:0]   sum_shift_c;

  // The single bit cell always sees the current LSBs and the carry flop.
  FA_X1 u_fa (
    .A  (a_sr_q[0]),
    .B  (b_sr_q[0]),
    .CI (carry_q),
    .CO (fa_co_c),
    .S  (fa_s_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the sum LSB.
  // The widened shift also covers WIDTH=1 without a degenerate slice.
  assign sum_shift_c = WIDTH'({fa_s_c, sum_sr_q} >> 1);

  // State register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      co_q     <= co_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath sequencing; START is only looked at in IDLE and FIN.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    co_d     = co_q;

    unique case (state_q)
      IDLE, FIN: begin
        if (START) begin
          a_sr_d   = A;
          b_sr_d   = B;
          sum_sr_d = '0;
          carry_d  = CI;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        sum_sr_d = sum_shift_c;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_co_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = sum_shift_c;
          co_d    = fa_co_c;
          state_d = FIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign S    = s_q;
  assign CO   = co_q;

endmodule
